// File: rtl/riscv_pkg.sv
// Shared RISC-V decode types for the issue controller.
//   opcode_t        : base-ISA major opcodes the controller understands
//   decoded_instr_t : record passed decode -> issue -> ALU; the opcode is kept
//                     as raw bits so that unknown encodings can be carried and
//                     rejected in issue
//   uses_rs1/uses_rs2/writes_rd/is_legal_opcode : per-opcode operand rules
package riscv_pkg;

  localparam int NUM_REGS = 32;

  typedef logic [4:0] register_name_t;

  typedef enum logic [6:0] {
    OP_LOAD    = 7'b0000011,
    OP_REG_IMM = 7'b0010011,
    OP_AUIPC   = 7'b0010111,
    OP_STORE   = 7'b0100011,
    OP_REG_REG = 7'b0110011,
    OP_LUI     = 7'b0110111,
    OP_BRANCH  = 7'b1100011,
    OP_JALR    = 7'b1100111,
    OP_JAL     = 7'b1101111
  } opcode_t;

  typedef struct packed {
    logic [6:0]     opcode;
    register_name_t rd;
    register_name_t rs1;
    register_name_t rs2;
    logic [2:0]     funct3;
    logic [6:0]     funct7;
    logic [31:0]    imm;
  } decoded_instr_t;

  function automatic logic is_legal_opcode(logic [6:0] op);
    case (op)
      OP_LOAD, OP_REG_IMM, OP_AUIPC, OP_STORE, OP_REG_REG,
      OP_LUI, OP_BRANCH, OP_JALR, OP_JAL: return 1'b1;
      default:                            return 1'b0;
    endcase
  endfunction

  function automatic logic uses_rs1(opcode_t op);
    case (op)
      OP_REG_REG, OP_STORE, OP_BRANCH,
      OP_REG_IMM, OP_LOAD, OP_JALR: return 1'b1;
      default:                      return 1'b0;
    endcase
  endfunction

  function automatic logic uses_rs2(opcode_t op);
    case (op)
      OP_REG_REG, OP_STORE, OP_BRANCH: return 1'b1;
      default:                         return 1'b0;
    endcase
  endfunction

  // Only legal opcodes are callers' concern; STORE/BRANCH reuse the rd field
  // for immediate bits, so they must never mark a register busy.
  function automatic logic writes_rd(opcode_t op);
    case (op)
      OP_LOAD, OP_REG_IMM, OP_AUIPC, OP_REG_REG,
      OP_LUI, OP_JALR, OP_JAL: return 1'b1;
      default:                 return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/riscv_scoreboard.sv
// Pending-write scoreboard: one busy bit per architectural register.
//   clk, rst          : clock, async active-high reset
//   flush             : clear every busy bit
//   set_en/set_rd     : mark a register busy (issue)
//   clr_en/clr_rd     : mark a register free (writeback)
//   rs1/rs2/rd        : lookup addresses
//   rs1_busy/rs2_busy/rd_busy : registered busy state of the looked-up regs
// x0 is hard-wired free.
module riscv_scoreboard
  import riscv_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       flush,
  input  logic       set_en,
  input  logic [4:0] set_rd,
  input  logic       clr_en,
  input  logic [4:0] clr_rd,
  input  logic [4:0] rs1,
  input  logic [4:0] rs2,
  input  logic [4:0] rd,
  output logic       rs1_busy,
  output logic       rs2_busy,
  output logic       rd_busy
);

  logic [NUM_REGS-1:0] busy, busy_nxt;

  // Set and clear never hit the same register: WAW blocks issue to a busy rd.
  always_comb begin
    busy_nxt = busy;
    if (clr_en) busy_nxt[clr_rd] = 1'b0;
    if (set_en) busy_nxt[set_rd] = 1'b1;
    busy_nxt[0] = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)        busy <= '0;
    else if (flush) busy <= '0;
    else            busy <= busy_nxt;
  end

  assign rs1_busy = busy[rs1];
  assign rs2_busy = busy[rs2];
  assign rd_busy  = busy[rd];

endmodule

// File: rtl/riscv_issue_ctrl.sv
// In-order issue controller between decode and the ALU.
//   clk, rst                     : clock, async active-high reset
//   dec_valid/dec_ready/dec_instr: decode handshake into holding register H
//   alu_valid/alu_ready/alu_instr: issue handshake out of output register O
//   wb_valid/wb_rd               : writeback completion, frees a register
//   flush                        : drop H, O, scoreboard and outstanding count
//   illegal                      : pulse when H holds an unknown opcode (dropped)
//   issue_cnt/stall_cnt          : saturating performance counters
module riscv_issue_ctrl
  import riscv_pkg::*;
#(
  parameter int MAX_OUTSTANDING = 4,
  parameter int CNT_W           = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             dec_valid,
  output logic             dec_ready,
  input  decoded_instr_t   dec_instr,
  output logic             alu_valid,
  input  logic             alu_ready,
  output decoded_instr_t   alu_instr,
  input  logic             wb_valid,
  input  logic [4:0]       wb_rd,
  input  logic             flush,
  output logic             illegal,
  output logic [CNT_W-1:0] issue_cnt,
  output logic [CNT_W-1:0] stall_cnt
);

  localparam int OUT_W = 4;

  logic           h_valid, o_valid;
  decoded_instr_t h_instr, o_instr;
  logic [OUT_W-1:0] outstanding;

  opcode_t h_op;
  logic    h_legal, hazard, issue, drop, wb_take, dec_hs, set_en;
  logic    rs1_busy, rs2_busy, rd_busy;

  assign h_op    = opcode_t'(h_instr.opcode);
  assign h_legal = is_legal_opcode(h_instr.opcode);

  assign hazard = (uses_rs1(h_op)  && rs1_busy) ||
                  (uses_rs2(h_op)  && rs2_busy) ||
                  (writes_rd(h_op) && rd_busy);

  assign issue = h_valid && h_legal && !hazard && (!o_valid || alu_ready) &&
                 (outstanding < OUT_W'(MAX_OUTSTANDING)) && !flush;

  assign drop    = h_valid && !h_legal;
  // A writeback with nothing outstanding is spurious and ignored entirely.
  assign wb_take = wb_valid && (outstanding != '0) && !flush;

  assign dec_ready = !h_valid || issue;
  assign dec_hs    = dec_valid && dec_ready;
  assign illegal   = drop;

  assign set_en = issue && writes_rd(h_op) && (h_instr.rd != 5'd0);

  riscv_scoreboard u_sb (
    .clk      (clk),
    .rst      (rst),
    .flush    (flush),
    .set_en   (set_en),
    .set_rd   (h_instr.rd),
    .clr_en   (wb_take),
    .clr_rd   (wb_rd),
    .rs1      (h_instr.rs1),
    .rs2      (h_instr.rs2),
    .rd       (h_instr.rd),
    .rs1_busy (rs1_busy),
    .rs2_busy (rs2_busy),
    .rd_busy  (rd_busy)
  );

  // Holding register: a flush also discards any same-cycle decode handshake.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      h_valid <= 1'b0;
      h_instr <= '0;
    end else if (flush) begin
      h_valid <= 1'b0;
    end else if (dec_hs) begin
      h_valid <= 1'b1;
      h_instr <= dec_instr;
    end else if (issue || drop) begin
      h_valid <= 1'b0;
    end
  end

  // Output register: payload only changes on issue, so it is stable under
  // backpressure.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      o_valid <= 1'b0;
      o_instr <= '0;
    end else if (flush) begin
      o_valid <= 1'b0;
    end else if (issue) begin
      o_valid <= 1'b1;
      o_instr <= h_instr;
    end else if (alu_ready) begin
      o_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)        outstanding <= '0;
    else if (flush) outstanding <= '0;
    else begin
      case ({issue, wb_take})
        2'b10:   outstanding <= outstanding + OUT_W'(1);
        2'b01:   outstanding <= outstanding - OUT_W'(1);
        default: outstanding <= outstanding;
      endcase
    end
  end

  // Counters survive flush; only reset clears them.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      issue_cnt <= '0;
      stall_cnt <= '0;
    end else begin
      if (issue && (issue_cnt != '1))
        issue_cnt <= issue_cnt + CNT_W'(1);
      if (h_valid && h_legal && !issue && (stall_cnt != '1))
        stall_cnt <= stall_cnt + CNT_W'(1);
    end
  end

  assign alu_valid = o_valid;
  assign alu_instr = o_instr;

endmodule

// File: tb/tb_riscv_issue_ctrl.sv
`timescale 1ns/1ps
module tb_riscv_issue_ctrl;
  import riscv_pkg::*;

  localparam int MAXO = 4;
  localparam int CW   = 32;
  localparam logic [6:0] LUI = 7'b0110111, AUIPC = 7'b0010111, JAL = 7'b1101111,
    JALR = 7'b1100111, BRANCH = 7'b1100011, LOAD = 7'b0000011, STORE = 7'b0100011,
    OPIMM = 7'b0010011, OPRR = 7'b0110011, BAD = 7'b1111111;

  logic clk = 0, rst = 0, dec_valid = 0, alu_ready = 1, wb_valid = 0, flush = 0;
  logic dec_ready, alu_valid, illegal;
  decoded_instr_t dec_instr = '0, alu_instr;
  logic [4:0] wb_rd = '0;
  logic [CW-1:0] issue_cnt, stall_cnt;

  always #5 clk = ~clk;

  riscv_issue_ctrl #(.MAX_OUTSTANDING(MAXO), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .dec_valid(dec_valid), .dec_ready(dec_ready),
    .dec_instr(dec_instr), .alu_valid(alu_valid), .alu_ready(alu_ready),
    .alu_instr(alu_instr), .wb_valid(wb_valid), .wb_rd(wb_rd), .flush(flush),
    .illegal(illegal), .issue_cnt(issue_cnt), .stall_cnt(stall_cnt));

  int tests = 0, fails = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // ---- ISA rules, stated as opcode sets ----
  function automatic bit b_legal(logic [6:0] op);
    return op inside {LUI, AUIPC, JAL, JALR, BRANCH, LOAD, STORE, OPIMM, OPRR};
  endfunction
  function automatic bit b_rs1(logic [6:0] op);
    return op inside {OPRR, STORE, BRANCH, OPIMM, LOAD, JALR};
  endfunction
  function automatic bit b_rs2(logic [6:0] op);
    return op inside {OPRR, STORE, BRANCH};
  endfunction
  function automatic bit b_rd(logic [6:0] op);
    return b_legal(op) && !(op inside {STORE, BRANCH});
  endfunction

  function automatic decoded_instr_t mk(logic [6:0] op, logic [4:0] rd, logic [4:0] rs1, logic [4:0] rs2);
    decoded_instr_t i;
    i = '0;
    i.opcode = op; i.rd = rd; i.rs1 = rs1; i.rs2 = rs2;
    i.funct3 = rd[2:0]; i.imm = 32'h0000_1000 + {27'd0, rd};
    return i;
  endfunction

  // ---- behavioural model ----
  bit m_hv, m_ov;
  decoded_instr_t m_h, m_o;
  bit m_busy [32];
  int m_out, m_ic, m_sc;
  int cyc = 0;
  bit auto_wb = 0;
  typedef struct { logic [4:0] rd; int due; } wb_t;
  wb_t wbq [$];

  function automatic bit m_issue_now();
    bit haz;
    haz = (b_rs1(m_h.opcode) && m_busy[m_h.rs1]) ||
          (b_rs2(m_h.opcode) && m_busy[m_h.rs2]) ||
          (b_rd(m_h.opcode)  && m_busy[m_h.rd]);
    return m_hv && b_legal(m_h.opcode) && !haz && (!m_ov || alu_ready) && (m_out < MAXO) && !flush;
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk or posedge rst) begin : model
    bit iss, hs, wbt, lg;
    if (rst) begin
      m_hv = 0; m_ov = 0; m_h = '0; m_o = '0; m_out = 0; m_ic = 0; m_sc = 0;
      foreach (m_busy[r]) m_busy[r] = 0;
      wbq.delete();
    end else begin
      iss = m_issue_now();
      lg  = b_legal(m_h.opcode);
      hs  = dec_valid && (!m_hv || iss);
      wbt = wb_valid && (m_out > 0) && !flush;
      if (auto_wb && m_ov && alu_ready && !flush)
        wbq.push_back('{b_rd(m_o.opcode) ? m_o.rd : 5'd0, cyc + 2});
      if (iss) m_ic++;
      if (m_hv && lg && !iss) m_sc++;
      if (flush) begin
        foreach (m_busy[r]) m_busy[r] = 0;
        m_out = 0;
      end else begin
        if (wbt) m_busy[wb_rd] = 0;
        if (iss && b_rd(m_h.opcode) && m_h.rd != 0) m_busy[m_h.rd] = 1;
        m_out = m_out + int'(iss) - int'(wbt);
      end
      if (flush) m_ov = 0;
      else if (iss) begin m_ov = 1; m_o = m_h; end
      else if (alu_ready) m_ov = 0;
      if (flush) m_hv = 0;
      else if (hs) begin m_hv = 1; m_h = dec_instr; end
      else if (iss || (m_hv && !lg)) m_hv = 0;
    end
  end

  // Writeback environment: completes each accepted ALU op two cycles later.
  always @(posedge clk) begin
    #2;
    if (auto_wb) begin
      if (wbq.size() > 0 && wbq[0].due <= cyc) begin
        wb_valid = 1; wb_rd = wbq[0].rd; void'(wbq.pop_front());
      end else wb_valid = 0;
    end
  end

  // ---- per-cycle compare ----
  int ill_seen = 0, av_seen = 0, first_av = -1, last_av = -1;
  always @(negedge clk) begin
    bit iss;
    iss = m_issue_now();
    chk("dec_ready", dec_ready, !m_hv || iss);
    chk("alu_valid", alu_valid, m_ov);
    if (m_ov) chk("alu_instr", alu_instr, m_o);
    chk("illegal", illegal, m_hv && !b_legal(m_h.opcode));
    chk("issue_cnt", issue_cnt, 64'(m_ic));
    chk("stall_cnt", stall_cnt, 64'(m_sc));
    if (illegal) ill_seen++;
    if (alu_valid) begin
      av_seen++;
      if (first_av < 0) first_av = cyc;
      last_av = cyc;
    end
  end

  // ---- stimulus helpers (called #1 after a rising edge) ----
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send(input decoded_instr_t i, output int hc);
    bit ok; int b;
    b = 0; ok = 0; hc = -1;
    dec_valid = 1; dec_instr = i;
    do begin
      @(negedge clk); ok = dec_ready; hc = cyc;
      @(posedge clk); #1; b++;
    end while (!ok && b < 60);
    if (!ok) begin
      tests++; fails++;
      $display("FAIL send_timeout: dec_ready stayed 0 for %0d cycles, required 1", b);
    end
    dec_valid = 0;
  endtask

  task automatic wb_pulse(input logic [4:0] rd);
    wb_valid = 1; wb_rd = rd;
    tick(1);
    wb_valid = 0;
  endtask

  task automatic do_reset();
    auto_wb = 0; dec_valid = 0; wb_valid = 0; flush = 0; alu_ready = 1;
    rst = 1;
    tick(1);
    rst = 0;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached, required $finish");
    $fatal(1, "watchdog");
  end

  int h1, h2, h3;
  initial begin
    // reset values, checked before any clock edge
    #2 rst = 1;
    #2;
    chk("rst_dec_ready", dec_ready, 1);
    chk("rst_alu_valid", alu_valid, 0);
    chk("rst_alu_instr", alu_instr, 0);
    chk("rst_illegal", illegal, 0);
    chk("rst_issue_cnt", issue_cnt, 0);
    chk("rst_stall_cnt", stall_cnt, 0);
    tick(2);
    rst = 0;

    // independent stream
    auto_wb = 1; first_av = -1; av_seen = 0;
    send(mk(OPIMM, 5'd1, 5'd0, 5'd0), h1);
    send(mk(OPIMM, 5'd2, 5'd0, 5'd0), h2);
    send(mk(OPIMM, 5'd3, 5'd0, 5'd0), h3);
    tick(8);
    chk("t1_hs_b2b", 64'(h3 - h1), 2);
    chk("t1_first_latency", 64'(first_av - h1), 2);
    chk("t1_av_count", 64'(av_seen), 3);
    chk("t1_av_span", 64'(last_av - first_av), 2);
    chk("t1_issue_cnt", issue_cnt, 3);
    chk("t1_stall_cnt", stall_cnt, 0);
    chk("t1_model_ic", 64'(m_ic), 3);

    // RAW stall
    do_reset();
    send(mk(OPRR, 5'd5, 5'd1, 5'd2), h1);
    send(mk(OPRR, 5'd6, 5'd5, 5'd3), h2);
    chk("t2_hs_gap", 64'(h2 - h1), 1);
    tick(6);
    wb_valid = 1; wb_rd = 5'd5;
    @(negedge clk); chk("t2_no_bypass", dec_ready, 0);
    @(posedge clk); #1; wb_valid = 0;
    @(negedge clk);
    chk("t2_unblock", dec_ready, 1);
    chk("t2_stall_cnt", stall_cnt, 7);
    chk("t2_model_sc", 64'(m_sc), 7);
    @(posedge clk); #1;
    @(negedge clk);
    chk("t2_sub_valid", alu_valid, 1);
    chk("t2_sub_rd", alu_instr.rd, 6);
    @(posedge clk); #1;
    chk("t2_issue_cnt", issue_cnt, 2);

    // WAW, x0 and operand usage
    do_reset();
    send(mk(LUI, 5'd0, 5'd0, 5'd0), h1);
    send(mk(LUI, 5'd0, 5'd0, 5'd0), h2);
    chk("t3_x0_b2b", 64'(h2 - h1), 1);
    tick(3);
    chk("t3_x0_stall", stall_cnt, 0);
    chk("t3_x0_issue", issue_cnt, 2);
    send(mk(LUI, 5'd7, 5'd0, 5'd0), h1);
    send(mk(OPIMM, 5'd7, 5'd0, 5'd0), h2);
    tick(4);
    chk("t3_waw_hold", issue_cnt, 3);
    chk("t3_waw_stall", stall_cnt, 4);
    wb_pulse(5'd7);
    send(mk(STORE, 5'd7, 5'd0, 5'd7), h3);
    tick(3);
    chk("t3_store_hold", issue_cnt, 4);
    wb_pulse(5'd7);
    tick(1);
    wb_pulse(5'd0);
    wb_pulse(5'd0);
    send(mk(LUI, 5'd7, 5'd0, 5'd0), h1);
    tick(2);
    chk("t3_store_nobusy", issue_cnt, 6);
    chk("t3_total_stall", stall_cnt, 9);

    // outstanding limit and backpressure
    do_reset();
    for (int r = 1; r <= 5; r++) send(mk(OPIMM, 5'(r), 5'd0, 5'd0), h1);
    tick(3);
    chk("t4_limit_issue", issue_cnt, 4);
    chk("t4_limit_ready", dec_ready, 0);
    chk("t4_limit_av", alu_valid, 0);
    chk("t4_limit_stall", stall_cnt, 3);
    alu_ready = 0;
    wb_pulse(5'd1);
    wb_pulse(5'd2);
    send(mk(OPIMM, 5'd6, 5'd0, 5'd0), h1);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("t4_bp_valid", alu_valid, 1);
      chk("t4_bp_rd", alu_instr.rd, 5);
      chk("t4_bp_ready", dec_ready, 0);
      @(posedge clk); #1;
    end
    alu_ready = 1;
    tick(2);
    chk("t4_after_bp", issue_cnt, 6);

    // illegal opcode
    do_reset();
    auto_wb = 1; ill_seen = 0; av_seen = 0;
    send(mk(BAD, 5'd3, 5'd0, 5'd0), h1);
    send(mk(OPIMM, 5'd3, 5'd0, 5'd0), h2);
    tick(5);
    chk("t5_ill_pulses", 64'(ill_seen), 1);
    chk("t5_av_count", 64'(av_seen), 1);
    chk("t5_issue_cnt", issue_cnt, 1);
    chk("t5_stall_cnt", stall_cnt, 0);

    // flush
    do_reset();
    alu_ready = 0;
    send(mk(OPIMM, 5'd4, 5'd0, 5'd0), h1);
    send(mk(OPRR, 5'd8, 5'd4, 5'd4), h2);
    tick(1);
    flush = 1;
    tick(1);
    flush = 0;
    @(negedge clk);
    chk("t6_flush_av", alu_valid, 0);
    chk("t6_flush_ready", dec_ready, 1);
    chk("t6_flush_ic", issue_cnt, 1);
    chk("t6_flush_sc", stall_cnt, 2);
    @(posedge clk); #1;
    alu_ready = 1;
    send(mk(OPRR, 5'd8, 5'd4, 5'd4), h1);
    tick(2);
    chk("t6_post_issue", issue_cnt, 2);
    chk("t6_post_stall", stall_cnt, 2);

    // asynchronous reset mid-stream
    auto_wb = 1;
    send(mk(OPIMM, 5'd1, 5'd0, 5'd0), h1);
    send(mk(OPIMM, 5'd2, 5'd0, 5'd0), h2);
    dec_valid = 1; dec_instr = mk(OPIMM, 5'd3, 5'd0, 5'd0);
    #2 rst = 1;
    #1;
    chk("ar_dec_ready", dec_ready, 1);
    chk("ar_alu_valid", alu_valid, 0);
    chk("ar_alu_instr", alu_instr, 0);
    chk("ar_illegal", illegal, 0);
    chk("ar_issue_cnt", issue_cnt, 0);
    chk("ar_stall_cnt", stall_cnt, 0);
    dec_valid = 0;
    @(posedge clk); #1;
    rst = 0;
    send(mk(OPIMM, 5'd9, 5'd0, 5'd0), h1);
    tick(4);
    chk("ar_resume", issue_cnt, 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/riscv_issue_ctrl.md
# riscv_issue_ctrl

In-order issue controller between decode and the ALU/execute datapath. It accepts `decoded_instr_t` records from decode, tracks pending destination writes in a 32-entry scoreboard, and holds any instruction that has a RAW or WAW hazard. Hazard-free instructions are issued to the ALU over a valid/ready handshake. It also keeps issue and stall performance counters.

## Interface
- `MAX_OUTSTANDING`, default 4: maximum issued instructions not yet written back (1..15).
- `CNT_W`, default 32: width of the performance counters.
- `clk` in 1: sole clock, rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `dec_valid` in 1: decode offers `dec_instr`.
- `dec_ready` out 1: controller accepts `dec_instr` this cycle.
- `dec_instr` in `decoded_instr_t`: decoded instruction.
- `alu_valid` out 1: `alu_instr` is valid.
- `alu_ready` in 1: ALU accepts `alu_instr`.
- `alu_instr` out `decoded_instr_t`: issued instruction (registered).
- `wb_valid` in 1: writeback completes for `wb_rd`.
- `wb_rd` in 5 (`register_name_t`): register being written back.
- `flush` in 1: synchronous pipeline flush.
- `illegal` out 1: one-cycle pulse when an unknown opcode is dropped.
- `issue_cnt` out `CNT_W`: saturating count of issued instructions.
- `stall_cnt` out `CNT_W`: saturating count of hazard/backpressure stall cycles.

## Operation
- **Holding register H:** one entry.
  - `dec_ready = !H.valid || issue`.
  - A handshake (`dec_valid && dec_ready`) loads H.
- **Output register O:** drives `alu_valid` and `alu_instr`.
  - O clears on `alu_valid && alu_ready` unless it is reloaded in the same cycle.
- **Operand usage by opcode:**
  - REG_REG, STORE, BRANCH: use rs1 and rs2.
  - REG_IMM, LOAD, JALR: use rs1 only.
  - LUI, AUIPC, JAL: use no source registers.
- **Destination writes:** every opcode writes rd except STORE and BRANCH. An rd of x0 is never marked busy.
- **Hazard:** a hazard exists when a used source register is busy (RAW) or when the destination rd is busy (WAW).
- **Issue condition:** `issue = H.valid && !hazard && (!O.valid || alu_ready) && outstanding < MAX_OUTSTANDING && !flush`.
- **On issue:**
  - O loads H.
  - `busy[rd]` is set (if the instruction writes rd and rd ≠ x0).
  - `outstanding` increments.
- **On `wb_valid`:**
  - `busy[wb_rd]` clears.
  - `outstanding` decrements; if it is already 0, the writeback is ignored.
- **Illegal opcode:** an opcode outside `opcode_t` in H is dropped in its first cycle without issuing, and `illegal` pulses.
- **Flush:** clears H.valid, O.valid, all busy bits and `outstanding`. A `wb_valid` in the flush cycle is ignored. A decode handshake in the flush cycle is discarded.
- **Counters:**
  - `stall_cnt` increments in every cycle where H.valid is set, the opcode is legal, and there is no issue.
  - `issue_cnt` increments on each issue.
  - Both saturate at all-ones and are not cleared by flush.

## Timing
- **Reset values:** `dec_ready`=1, `alu_valid`=0, `alu_instr`='0, `illegal`=0, both counters 0, all busy bits 0, `outstanding`=0.
- **Latency:** a decode handshake in cycle N gives H valid in N+1, and `alu_valid` is high in N+2 at the earliest.
- **Throughput:** with no hazards and `alu_ready` held high, one instruction issues per cycle.
- **Scoreboard visibility:** the hazard check reads registered busy bits.
  - A writeback in cycle N unblocks a dependent instruction for issue in N+1 (no same-cycle bypass).
  - A busy bit set by an issue in cycle N blocks a dependent instruction from cycle N+1.
- **Simultaneous set/clear of the same register:** cannot happen, because the WAW check forbids setting a bit that is already busy.
- **Simultaneous issue and writeback:** `outstanding` stays unchanged.
- **Backpressure:** O holds stable while `alu_valid && !alu_ready`.
- **Reset asserted mid-operation:** all state returns to reset values immediately. In-flight instructions are lost, and the environment must reset the ALU as well.

## Structure
- **Additions to `riscv_pkg`:**
  - functions `uses_rs1(opcode_t)`, `uses_rs2(opcode_t)`, `writes_rd(opcode_t)` and `is_legal_opcode(logic[6:0])`;
  - constant `NUM_REGS = 32`.
- **Sub-module `riscv_scoreboard`:**
  - 32-bit busy vector with set/clear ports, flush, and combinational `rs1_busy`/`rs2_busy`/`rd_busy` lookups;
  - bit 0 is hard-wired to 0.
- **Top level:** H/O registers, outstanding counter, issue logic and performance counters.

## Test plan
- **Independent stream:** back-to-back ADDI x1, ADDI x2, ADDI x3 with `alu_ready`=1 and writeback 2 cycles after issue → one `alu_valid` per cycle, first in cycle 2; `issue_cnt`=3, `stall_cnt`=0.
- **RAW stall:** ADD x5,x1,x2 followed by SUB x6,x5,x3, with writeback of x5 held until cycle 10 → SUB issues in cycle 11; `stall_cnt` increments once per stalled cycle.
- **WAW/x0 and operand usage:** two LUI x0 back to back issue without stall. LUI x7 then ADDI x7,x0,1 → the ADDI waits for x7's writeback. A STORE using rs2=x7 stalls on x7 but sets no busy bit.
- **Outstanding limit and backpressure:** `MAX_OUTSTANDING`=4, no writebacks → exactly 4 issue and the fifth holds. Dropping `alu_ready` for 3 cycles keeps `alu_instr` stable and `dec_ready` low while H is full.
- **Illegal opcode:** opcode 7'b1111111 → `illegal` pulses once, no `alu_valid`, and the next legal instruction issues normally.
- **Flush and reset:** `flush` with H and O valid and x4 busy → next cycle `alu_valid`=0, ADD x8,x4,x4 issues without stall. Asserting `rst` asynchronously mid-stream returns all outputs to their reset values before the next clock edge.
